avalon_mm_arbiter: RTL and testbench
====================================

# avalon_mm_arbiter

Round-robin arbiter and sequencer sharing one Avalon-MM slave port (the 4-bit control/status register slave) between N requesters. Each requester posts a single read or write. The block grants one requester at a time, drives exactly one `avs_s0_write` or `avs_s0_read` pulse with the latched address and data, and waits out the slave's fixed read latency. It then returns a one-cycle `ack` (with read data for reads) to the granted requester. It sits between the control-path masters and the slave's `avs_s0_*` port.

## Interface
- `N`, 4: number of requesters (2..8).
- `AW`, 4: address width.
- `DW`, 4: data width.
- `RD_LAT`, 1: slave read latency in cycles, counted from the `avs_s0_read` cycle to the cycle in which `avs_s0_readdata` is valid (1..7).
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  N  per-requester request; held high until that requester's `ack`.
- `req_write`  in  N  per-requester: 1 means write, 0 means read; stable while `req` is high.
- `req_addr`  in  N*AW  packed addresses; requester i uses bits [i*AW +: AW].
- `req_wdata`  in  N*DW  packed write data, same packing as `req_addr`.
- `grant`  out  N  one-hot registered grant; high from the ISSUE cycle through the DONE cycle.
- `ack`  out  N  one-hot, one-cycle completion pulse.
- `rdata`  out  DW  read data; valid in the `ack` cycle of a read, holds its value otherwise.
- `busy`  out  1  high in every state except IDLE.
- `avs_s0_address`  out  AW  slave address.
- `avs_s0_writedata`  out  DW  slave write data.
- `avs_s0_write`  out  1  slave write strobe.
- `avs_s0_read`  out  1  slave read strobe.
- `avs_s0_readdata`  in  DW  slave read data.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If any `req` bit is high, select the winner by round robin and latch its `req_write`, `req_addr` and `req_wdata`.
  - Set `grant` and move to ISSUE.
  - If no request, stay in IDLE.
- Round robin: search starts at index `last+1` mod N. `last` is the most recent grantee and resets to N-1, so requester 0 has top priority after reset. `last` updates when the grant is taken.
- ISSUE (exactly 1 cycle):
  - Drive `avs_s0_address` and `avs_s0_writedata` from the latched values.
  - Write: assert `avs_s0_write`, then go to DONE.
  - Read: assert `avs_s0_read`, load the wait counter with `RD_LAT`, then go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - In the final WAIT cycle (counter = 1), register `avs_s0_readdata` into `rdata`, then go to DONE.
- DONE (1 cycle): assert `ack[grantee]`, then return to IDLE.
- `avs_s0_write` and `avs_s0_read` are never high together and never high outside ISSUE.
- `avs_s0_address` and `avs_s0_writedata` hold their last driven values outside ISSUE.
- Requesters whose `req` bit is low are never granted. Changing `req_*` of a non-granted requester has no effect on the transaction in flight.
- Requester contract: drop `req` no later than the cycle after its `ack`. A `req` still high in the following IDLE cycle is treated as a new request.

## Timing
- Reset values (asynchronous): state IDLE, `last` = N-1, counter 0. All outputs 0: `grant`, `ack`, `rdata`, `busy`, `avs_s0_*`.
- Reset asserted mid-transaction aborts it: no `ack` is issued, and the strobe drops immediately.
- Cycle numbering: cycle 0 is the IDLE cycle in which `req` is sampled high.
- Write transaction:
  - `avs_s0_write` high in cycle 1.
  - `ack` in cycle 2.
  - Total 3 cycles per write.
- Read transaction:
  - `avs_s0_read` high in cycle 1.
  - WAIT runs cycles 2..1+RD_LAT, and `avs_s0_readdata` is sampled in cycle 1+RD_LAT.
  - `ack` and valid `rdata` in cycle 2+RD_LAT. With RD_LAT = 1: `ack` in cycle 3, 4 cycles total.
- Minimum gap between slave strobes of back-to-back writes: 3 cycles. The arbiter has one transaction in flight at a time.
- Simultaneous requests in the same cycle are resolved strictly by the round-robin order. No requester waits more than N-1 transactions.

## Test plan
- Single write: `req[0]` with address 0x3, data 0xA → `avs_s0_write` = 1 with addr 3 / data A in cycle 1; `ack` = 0001 in cycle 2; `busy` low in cycle 3.
- Single read, RD_LAT = 1: slave model returns 0x5 one cycle after read → `avs_s0_read` in cycle 1, `ack[0]` and `rdata` = 0x5 in cycle 3, no write strobe.
- All four `req` high together from reset, held until each `ack` → grant order 0, 1, 2, 3. Then raise `req[1]` and `req[0]` together → grant order 1, 0 is not expected; `last` = 3, so order is 0, then 1.
- Fairness: `req[2]` held permanently (re-raised after each `ack`) while `req[0]` is raised once → `req[0]` is granted in the next IDLE after the current transaction.
- RD_LAT = 3 build: read ack arrives in cycle 5. Assert `rst` in cycle 2 of a read → all outputs 0 immediately, no `ack`, and a fresh request after reset completes normally.
- Protocol assertion run (random `req` stimulus, 10k cycles) → `avs_s0_write` and `avs_s0_read` never both high; `grant` and `ack` always one-hot or zero; every `ack` matches a prior `req`.

Source files
------------

// File: rtl/avalon_mm_arbiter_if.sv
// Bundle between the control-path requesters, the arbiter and the shared
// Avalon-MM CSR slave port.
//   master : arbiter side (samples requests and slave read data, drives
//            grant/ack/rdata/busy and the avs_s0_* command signals)
//   slave  : environment side (requesters plus the CSR slave)
interface avalon_mm_arbiter_if #(
   parameter int unsigned N  = 4,
   parameter int unsigned AW = 4,
   parameter int unsigned DW = 4
);
   logic [N-1:0]    req;
   logic [N-1:0]    req_write;
   logic [N*AW-1:0] req_addr;
   logic [N*DW-1:0] req_wdata;
   logic [N-1:0]    grant;
   logic [N-1:0]    ack;
   logic [DW-1:0]   rdata;
   logic            busy;
   logic [AW-1:0]   avs_s0_address;
   logic [DW-1:0]   avs_s0_writedata;
   logic            avs_s0_write;
   logic            avs_s0_read;
   logic [DW-1:0]   avs_s0_readdata;

   modport master (
      input  req, req_write, req_addr, req_wdata, avs_s0_readdata,
      output grant, ack, rdata, busy,
             avs_s0_address, avs_s0_writedata, avs_s0_write, avs_s0_read
   );

   modport slave (
      output req, req_write, req_addr, req_wdata, avs_s0_readdata,
      input  grant, ack, rdata, busy,
             avs_s0_address, avs_s0_writedata, avs_s0_write, avs_s0_read
   );
endinterface

// File: rtl/avalon_mm_arbiter.sv
// Round-robin arbiter/sequencer sharing one Avalon-MM CSR slave port between
// N requesters, one transaction in flight at a time.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : requester side (req, req_write, req_addr, req_wdata -> grant, ack,
//          rdata, busy) and slave side (avs_s0_* command out, readdata in)
// Writes take 3 cycles (IDLE, ISSUE, DONE); reads take 3 + RD_LAT cycles.
module avalon_mm_arbiter #(
   parameter int unsigned N      = 4,
   parameter int unsigned AW     = 4,
   parameter int unsigned DW     = 4,
   parameter int unsigned RD_LAT = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   avalon_mm_arbiter_if.master  bus
);

   localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned CW = $clog2(RD_LAT + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

   state_e          state_q, state_d;
   logic [IW-1:0]   last_q,  last_d;
   logic [CW-1:0]   cnt_q,   cnt_d;
   logic            wr_q,    wr_d;
   logic [N-1:0]    grant_q, grant_d;
   logic [N-1:0]    ack_q,   ack_d;
   logic [DW-1:0]   rdata_q, rdata_d;
   logic            busy_q,  busy_d;
   logic [AW-1:0]   addr_q,  addr_d;
   logic [DW-1:0]   wdata_q, wdata_d;
   logic            write_q, write_d;
   logic            read_q,  read_d;

   logic            win_vld;
   logic [IW-1:0]   win_idx;
   logic [IW-1:0]   cand;
   logic            sel_write;
   logic [AW-1:0]   sel_addr;
   logic [DW-1:0]   sel_wdata;

   // Round-robin search: first requester at or after last+1 (mod N).
   always_comb begin
      win_vld = 1'b0;
      win_idx = '0;
      cand    = '0;
      for (int unsigned k = 1; k <= N; k++) begin
         cand = IW'((32'(last_q) + k) % N);
         if (!win_vld && bus.req[cand]) begin
            win_vld = 1'b1;
            win_idx = cand;
         end
      end
   end

   // Pick the winner's command fields out of the packed request buses.
   always_comb begin
      sel_write = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (win_idx == IW'(i)) begin
            sel_write = bus.req_write[i];
            sel_addr  = bus.req_addr[i*AW +: AW];
            sel_wdata = bus.req_wdata[i*DW +: DW];
         end
      end
   end

   // Next-state and registered-output logic.
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      wr_d    = wr_q;
      grant_d = grant_q;
      ack_d   = '0;
      rdata_d = rdata_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      write_d = 1'b0;
      read_d  = 1'b0;

      unique case (state_q)
         IDLE: begin
            // Strobe and command are registered here so they appear in ISSUE.
            if (win_vld) begin
               state_d = ISSUE;
               last_d  = win_idx;
               wr_d    = sel_write;
               addr_d  = sel_addr;
               wdata_d = sel_wdata;
               grant_d = N'(1) << win_idx;
               write_d = sel_write;
               read_d  = !sel_write;
            end
         end
         ISSUE: begin
            if (wr_q) begin
               state_d = DONE;
               ack_d   = grant_q;
            end else begin
               state_d = WAIT;
               cnt_d   = CW'(RD_LAT);
            end
         end
         WAIT: begin
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               rdata_d = bus.avs_s0_readdata;
               state_d = DONE;
               ack_d   = grant_q;
            end
         end
         DONE: begin
            state_d = IDLE;
            grant_d = '0;
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         last_q  <= IW'(N - 1);
         cnt_q   <= '0;
         wr_q    <= 1'b0;
         grant_q <= '0;
         ack_q   <= '0;
         rdata_q <= '0;
         busy_q  <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         write_q <= 1'b0;
         read_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         wr_q    <= wr_d;
         grant_q <= grant_d;
         ack_q   <= ack_d;
         rdata_q <= rdata_d;
         busy_q  <= busy_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         write_q <= write_d;
         read_q  <= read_d;
      end
   end

   assign bus.grant            = grant_q;
   assign bus.ack              = ack_q;
   assign bus.rdata            = rdata_q;
   assign bus.busy             = busy_q;
   assign bus.avs_s0_address   = addr_q;
   assign bus.avs_s0_writedata = wdata_q;
   assign bus.avs_s0_write     = write_q;
   assign bus.avs_s0_read      = read_q;

endmodule

// File: tb/tb_avalon_mm_arbiter.sv
// Bench for avalon_mm_arbiter: a RD_LAT=1 instance checked every cycle
// against a transaction-level model (directed scenarios then random traffic),
// and a RD_LAT=3 instance for read latency and mid-transaction reset.
module tb_avalon_mm_arbiter;

   localparam int N   = 4;
   localparam int AW  = 4;
   localparam int DW  = 4;
   localparam int RDL = 1;

   logic clk  = 1'b0;
   logic rst  = 1'b1;
   logic rst3 = 1'b1;

   always #5 clk = ~clk;

   avalon_mm_arbiter_if #(.N(N), .AW(AW), .DW(DW)) bus1 ();
   avalon_mm_arbiter_if #(.N(N), .AW(AW), .DW(DW)) bus3 ();

   avalon_mm_arbiter #(.N(N), .AW(AW), .DW(DW), .RD_LAT(RDL)) dut1 (
      .clk (clk),
      .rst (rst),
      .bus (bus1)
   );

   avalon_mm_arbiter #(.N(N), .AW(AW), .DW(DW), .RD_LAT(3)) dut3 (
      .clk (clk),
      .rst (rst3),
      .bus (bus3)
   );

   int unsigned n_chk = 0;
   int unsigned n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   function automatic logic [N-1:0] oh(input int i);
      return N'(1) << i;
   endfunction

   // requester-side state for dut1
   bit            pend    [N];
   bit            sticky  [N];
   bit            r_wr    [N];
   logic [AW-1:0] r_addr  [N];
   logic [DW-1:0] r_wdata [N];

   // transaction-level model of dut1
   int            cyc;
   int            m_last;
   int            next_free;
   bit            t_vld;
   int            t_win, t_start, t_end;
   bit            t_wr;
   logic [AW-1:0] t_addr;
   logic [DW-1:0] t_wdata, t_rdv;
   logic [AW-1:0] e_addr;
   logic [DW-1:0] e_wdata, e_rdata;
   int            ack_log [$];

   task automatic drive();
      for (int i = 0; i < N; i++) begin
         bus1.req[i]                = pend[i];
         bus1.req_write[i]          = r_wr[i];
         bus1.req_addr[i*AW +: AW]  = r_addr[i];
         bus1.req_wdata[i*DW +: DW] = r_wdata[i];
      end
   endtask

   task automatic raise(input int i, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
      pend[i] = 1'b1; r_wr[i] = wr; r_addr[i] = a; r_wdata[i] = d;
   endtask

   task automatic raise_rand(input int i);
      raise(i, 1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom));
   endtask

   // Check outputs of the current cycle, then update requester behaviour.
   task automatic step_begin(input bit rnd);
      logic [N-1:0] eg, ea;
      bit ein, ewr, erd;
      bit dropped [N];
      ein = t_vld && cyc > t_start && cyc <= t_end;
      eg  = ein ? oh(t_win) : '0;
      ea  = (t_vld && cyc == t_end) ? oh(t_win) : '0;
      ewr = t_vld && cyc == t_start + 1 && t_wr;
      erd = t_vld && cyc == t_start + 1 && !t_wr;
      if (t_vld && cyc == t_start + 1) begin
         e_addr  = t_addr;
         e_wdata = t_wdata;
      end
      if (t_vld && !t_wr && cyc == t_end) e_rdata = t_rdv;
      chk("grant", 32'(bus1.grant), 32'(eg));
      chk("ack",   32'(bus1.ack),   32'(ea));
      chk("busy",  32'(bus1.busy),  32'(ein));
      chk("write", 32'(bus1.avs_s0_write), 32'(ewr));
      chk("read",  32'(bus1.avs_s0_read),  32'(erd));
      chk("addr",  32'(bus1.avs_s0_address),   32'(e_addr));
      chk("wdata", 32'(bus1.avs_s0_writedata), 32'(e_wdata));
      chk("rdata", 32'(bus1.rdata), 32'(e_rdata));
      for (int i = 0; i < N; i++) begin
         if (bus1.ack[i]) ack_log.push_back(i);
         dropped[i] = 1'b0;
      end
      if (t_vld && cyc == t_end) begin
         pend[t_win]    = 1'b0;
         dropped[t_win] = 1'b1;
      end
      for (int i = 0; i < N; i++) begin
         if (!pend[i] && !dropped[i]) begin
            if (sticky[i] || (rnd && $urandom_range(0, 3) == 0)) raise_rand(i);
         end else if (pend[i] && rnd && !(t_vld && t_win == i && cyc <= t_end)
                      && $urandom_range(0, 3) == 0) begin
            // waiting requesters may change their command freely
            r_addr[i]  = AW'($urandom);
            r_wdata[i] = DW'($urandom);
         end
      end
   endtask

   // Drive slave data, apply inputs, and let the model arbitrate when free.
   task automatic step_end();
      bit found;
      int idx;
      bus1.avs_s0_readdata = DW'($urandom);
      if (t_vld && !t_wr && cyc == t_start + 1 + RDL) t_rdv = bus1.avs_s0_readdata;
      drive();
      found = 1'b0;
      if (cyc >= next_free) begin
         for (int k = 1; k <= N; k++) begin
            idx = (m_last + k) % N;
            if (!found && pend[idx]) begin
               found     = 1'b1;
               t_vld     = 1'b1;
               t_win     = idx;
               t_wr      = r_wr[idx];
               t_addr    = r_addr[idx];
               t_wdata   = r_wdata[idx];
               t_start   = cyc;
               t_end     = cyc + (r_wr[idx] ? 2 : 2 + RDL);
               next_free = t_end + 1;
               m_last    = idx;
            end
         end
      end
      cyc++;
   endtask

   task automatic tick(input bit rnd);
      @(negedge clk);
      step_begin(rnd);
      step_end();
   endtask

   task automatic reset1();
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < N; i++) begin
         pend[i] = 1'b0; sticky[i] = 1'b0;
      end
      drive();
      cyc = 0; m_last = N - 1; next_free = 0; t_vld = 1'b0;
      e_addr = '0; e_wdata = '0; e_rdata = '0;
      ack_log.delete();
      repeat (2) begin
         @(negedge clk);
         chk("rst_grant", 32'(bus1.grant), 32'h0);
         chk("rst_ack",   32'(bus1.ack),   32'h0);
         chk("rst_busy",  32'(bus1.busy),  32'h0);
         chk("rst_strb",  32'({bus1.avs_s0_write, bus1.avs_s0_read}), 32'h0);
         chk("rst_addr",  32'(bus1.avs_s0_address), 32'h0);
         chk("rst_rdata", 32'(bus1.rdata), 32'h0);
      end
      @(negedge clk);
      rst = 1'b0;
      step_begin(1'b0);
      step_end();
   endtask

   // RD_LAT=3 read by the requester(s) in g: checks cycles 1..7 after the IDLE
   // sample cycle; slave returns d only in cycle 4.
   task automatic l3_read_seq(input logic [N-1:0] g, input logic [DW-1:0] d, input logic [AW-1:0] a);
      for (int c = 1; c <= 7; c++) begin
         @(negedge clk);
         chk("l3_grant", 32'(bus3.grant), (c <= 5) ? 32'(g) : 32'h0);
         chk("l3_busy",  32'(bus3.busy),  (c <= 5) ? 32'h1 : 32'h0);
         chk("l3_read",  32'(bus3.avs_s0_read),  (c == 1) ? 32'h1 : 32'h0);
         chk("l3_write", 32'(bus3.avs_s0_write), 32'h0);
         chk("l3_ack",   32'(bus3.ack),   (c == 5) ? 32'(g) : 32'h0);
         chk("l3_rdata", 32'(bus3.rdata), (c >= 5) ? 32'(d) : 32'h0);
         chk("l3_addr",  32'(bus3.avs_s0_address), 32'(a));
         if (c == 5) bus3.req = '0;
         bus3.avs_s0_readdata = (c == 4) ? d : 4'h2;
      end
   endtask

   int exp_ord [6] = '{0, 1, 2, 3, 0, 1};
   int exp_fair [3] = '{2, 0, 2};

   initial begin
      for (int i = 0; i < N; i++) begin
         pend[i] = 1'b0; sticky[i] = 1'b0; r_wr[i] = 1'b0; r_addr[i] = '0; r_wdata[i] = '0;
      end
      drive();
      bus1.avs_s0_readdata = '0;
      bus3.req = '0; bus3.req_write = '0; bus3.req_addr = '0; bus3.req_wdata = '0;
      bus3.avs_s0_readdata = '0;

      // single write, then single read from requester 0
      reset1();
      @(negedge clk); step_begin(1'b0); raise(0, 1'b1, 4'h3, 4'hA); step_end();
      repeat (6) tick(1'b0);
      @(negedge clk); step_begin(1'b0); raise(0, 1'b0, 4'h7, 4'h0); step_end();
      repeat (7) tick(1'b0);

      // all four together from reset, then 1 and 0 together
      reset1();
      @(negedge clk); step_begin(1'b0);
      for (int i = 0; i < N; i++) raise_rand(i);
      step_end();
      repeat (25) tick(1'b0);
      @(negedge clk); step_begin(1'b0); raise(1, 1'b1, 4'h1, 4'h1); raise(0, 1'b0, 4'h2, 4'h0); step_end();
      repeat (12) tick(1'b0);
      chk("order_len", 32'(ack_log.size()), 32'd6);
      for (int i = 0; i < 6; i++)
         chk("order", (i < ack_log.size()) ? 32'(ack_log[i]) : 32'hFFFF_FFFF, 32'(exp_ord[i]));

      // fairness: requester 2 always re-requests, requester 0 asks once
      reset1();
      sticky[2] = 1'b1;
      tick(1'b0);
      @(negedge clk); step_begin(1'b0); raise(0, 1'b1, 4'h5, 4'h6); step_end();
      repeat (20) tick(1'b0);
      sticky[2] = 1'b0;
      repeat (8) tick(1'b0);
      for (int i = 0; i < 3; i++)
         chk("fair_order", (i < ack_log.size()) ? 32'(ack_log[i]) : 32'hFFFF_FFFF, 32'(exp_fair[i]));

      // random traffic, then drain
      reset1();
      repeat (3000) tick(1'b1);
      repeat (20) tick(1'b0);

      // RD_LAT=3 instance: plain read by requester 1
      @(negedge clk);
      rst3 = 1'b0;
      bus3.req = 4'b0010; bus3.req_write = '0; bus3.req_addr = 16'h0060;
      bus3.avs_s0_readdata = 4'h2;
      l3_read_seq(4'b0010, 4'h9, 4'h6);

      // read by requester 2 aborted by reset in its first WAIT cycle
      @(negedge clk);
      bus3.req = 4'b0100; bus3.req_addr = 16'h0C00;
      @(negedge clk);
      chk("ab_read", 32'(bus3.avs_s0_read), 32'h1);
      @(negedge clk);
      chk("ab_busy", 32'(bus3.busy), 32'h1);
      #1 rst3 = 1'b1;
      #1;
      chk("ab_grant", 32'(bus3.grant), 32'h0);
      chk("ab_busy0", 32'(bus3.busy),  32'h0);
      chk("ab_read0", 32'(bus3.avs_s0_read), 32'h0);
      chk("ab_rdata", 32'(bus3.rdata), 32'h0);
      chk("ab_addr",  32'(bus3.avs_s0_address), 32'h0);
      repeat (3) begin
         @(negedge clk);
         chk("ab_noack", 32'(bus3.ack), 32'h0);
      end
      @(negedge clk);
      rst3 = 1'b0;
      l3_read_seq(4'b0100, 4'hD, 4'hC);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
